decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered RV32I(+M) instruction decoder between fetch and execute; one instruction per valid/ready handshake.
// Latency: 1 cycle (accept at edge N, out_valid=1 after edge N); sustains 1 instr/cycle in pass-through.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while out_valid && !out_ready; flush drops held and incoming.
//
// Ports: clk/rst_n (async active-low); flush; in_valid/in_ready/in_instr/in_pc from fetch;
//        out_valid/out_ready plus decoded payload (out_opcode, out_rd/rs1/rs2, use flags, out_illegal, out_pc)
//        to execute; illegal_count is a saturating count of accepted illegal instructions.

package opcodes_pkg;
    typedef enum logic [5:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } opcode_out_t;
endpackage

module decode_stage
    import opcodes_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter bit EN_M            = 1'b1,
    parameter int CNT_W           = 8,
    parameter bit ZERO_UNUSED_IDX = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output opcode_out_t       out_opcode,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic              out_rd_wr,
    output logic              out_rs1_used,
    output logic              out_rs2_used,
    output logic              out_illegal,
    output logic [XLEN-1:0]   out_pc,
    output logic [CNT_W-1:0]  illegal_count
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_fld;

    assign opc    = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign rd_fld = in_instr[11:7];

    opcode_out_t dec_op;
    logic        dec_legal;
    logic        uses_rs1, uses_rs2, writes_rd;
    logic        dec_rs1_used, dec_rs2_used, dec_rd_wr;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;

    // Every opcode matched below ends in 2'b11, so a 7-bit match also enforces
    // the 32-bit encoding check on instr[1:0].
    always_comb begin
        dec_op    = OP_NOP;
        dec_legal = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (opc)
            7'b0110011: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
                case (f7)
                    7'h00: begin
                        dec_legal = 1'b1;
                        case (f3)
                            3'b000:  dec_op = OP_ADD;
                            3'b001:  dec_op = OP_SLL;
                            3'b010:  dec_op = OP_SLT;
                            3'b011:  dec_op = OP_SLTU;
                            3'b100:  dec_op = OP_XOR;
                            3'b101:  dec_op = OP_SRL;
                            3'b110:  dec_op = OP_OR;
                            default: dec_op = OP_AND;
                        endcase
                    end
                    7'h20: begin
                        if (f3 == 3'b000) begin dec_op = OP_SUB; dec_legal = 1'b1; end
                        if (f3 == 3'b101) begin dec_op = OP_SRA; dec_legal = 1'b1; end
                    end
                    7'h01: begin
                        if (EN_M) begin
                            dec_legal = 1'b1;
                            case (f3)
                                3'b000:  dec_op = OP_MUL;
                                3'b001:  dec_op = OP_MULH;
                                3'b010:  dec_op = OP_MULHSU;
                                3'b011:  dec_op = OP_MULHU;
                                3'b100:  dec_op = OP_DIV;
                                3'b101:  dec_op = OP_DIVU;
                                3'b110:  dec_op = OP_REM;
                                default: dec_op = OP_REMU;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
            7'b0010011: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                dec_legal = 1'b1;
                case (f3)
                    3'b000:  dec_op = OP_ADDI;
                    3'b010:  dec_op = OP_SLTI;
                    3'b011:  dec_op = OP_SLTIU;
                    3'b100:  dec_op = OP_XORI;
                    3'b110:  dec_op = OP_ORI;
                    3'b111:  dec_op = OP_ANDI;
                    3'b001: begin
                        dec_op    = OP_SLLI;
                        dec_legal = (f7 == 7'h00);
                    end
                    default: begin
                        dec_op    = (f7 == 7'h20) ? OP_SRAI : OP_SRLI;
                        dec_legal = (f7 == 7'h00) || (f7 == 7'h20);
                    end
                endcase
            end
            7'b0000011: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                dec_legal = 1'b1;
                case (f3)
                    3'b000:  dec_op = OP_LB;
                    3'b001:  dec_op = OP_LH;
                    3'b010:  dec_op = OP_LW;
                    3'b100:  dec_op = OP_LBU;
                    3'b101:  dec_op = OP_LHU;
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b0100011: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                dec_legal = 1'b1;
                case (f3)
                    3'b000:  dec_op = OP_SB;
                    3'b001:  dec_op = OP_SH;
                    3'b010:  dec_op = OP_SW;
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b1100011: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                dec_legal = 1'b1;
                case (f3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    3'b110:  dec_op = OP_BLTU;
                    3'b111:  dec_op = OP_BGEU;
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b1100111: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                dec_op    = OP_JALR;
                dec_legal = (f3 == 3'b000);
            end
            7'b0110111: begin dec_op = OP_LUI;   writes_rd = 1'b1; dec_legal = 1'b1; end
            7'b0010111: begin dec_op = OP_AUIPC; writes_rd = 1'b1; dec_legal = 1'b1; end
            7'b1101111: begin dec_op = OP_JAL;   writes_rd = 1'b1; dec_legal = 1'b1; end
            7'b0001111: dec_legal = 1'b1;   // fences: no-op in this pipeline
            7'b1110011: begin
                // Only the exact ECALL/EBREAK words are accepted.
                if (in_instr[31:7] == 25'h0000000) begin dec_op = OP_ECALL;  dec_legal = 1'b1; end
                if (in_instr[31:7] == 25'h0002000) begin dec_op = OP_EBREAK; dec_legal = 1'b1; end
            end
            default: ;
        endcase
        if (!dec_legal) begin
            dec_op = OP_NOP;
        end
    end

    assign dec_rs1_used = dec_legal && uses_rs1;
    assign dec_rs2_used = dec_legal && uses_rs2;
    assign dec_rd_wr    = dec_legal && writes_rd && (rd_fld != 5'd0);

    assign dec_rd  = (ZERO_UNUSED_IDX && !dec_rd_wr)    ? 5'd0 : rd_fld;
    assign dec_rs1 = (ZERO_UNUSED_IDX && !dec_rs1_used) ? 5'd0 : in_instr[19:15];
    assign dec_rs2 = (ZERO_UNUSED_IDX && !dec_rs2_used) ? 5'd0 : in_instr[24:20];

    logic acc;
    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_opcode    <= OP_NOP;
            out_rd        <= 5'd0;
            out_rs1       <= 5'd0;
            out_rs2       <= 5'd0;
            out_rd_wr     <= 1'b0;
            out_rs1_used  <= 1'b0;
            out_rs2_used  <= 1'b0;
            out_illegal   <= 1'b0;
            out_pc        <= '0;
            illegal_count <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (acc) begin
                out_valid    <= 1'b1;
                out_opcode   <= dec_op;
                out_rd       <= dec_rd;
                out_rs1      <= dec_rs1;
                out_rs2      <= dec_rs2;
                out_rd_wr    <= dec_rd_wr;
                out_rs1_used <= dec_rs1_used;
                out_rs2_used <= dec_rs2_used;
                out_illegal  <= !dec_legal;
                out_pc       <= in_pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc && !dec_legal && (illegal_count != '1)) begin
                illegal_count <= illegal_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (EN_M=1, CNT_W=2, ZERO_UNUSED_IDX=1).
// Drivers push expected decodes on acceptance; a negedge monitor compares whenever out_valid is high.
// Directed vectors with hand-decoded expectations cover legality, flags, stall, flush, saturation and async reset.
module tb_decode_stage;
    import opcodes_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    opcode_out_t out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_rd_wr, out_rs1_used, out_rs2_used, out_illegal;
    logic [31:0] out_pc;
    logic [1:0]  illegal_count;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EN_M(1'b1), .CNT_W(2), .ZERO_UNUSED_IDX(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd_wr(out_rd_wr), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
        .out_illegal(out_illegal), .out_pc(out_pc), .illegal_count(illegal_count)
    );

    typedef struct packed {
        opcode_out_t op;
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  flg;   // {rd_wr, rs1_used, rs2_used, illegal}
        logic [31:0] pc;
        logic [1:0]  cnt;
    } rec_t;

    rec_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [1:0]  mcnt = 2'd0;
    logic [31:0] pc_next = 32'h0000_1000;
    int          waited;

    function automatic rec_t mk(input opcode_out_t op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [3:0] flg);
        rec_t r;
        r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.flg = flg; r.pc = '0; r.cnt = '0;
        return r;
    endfunction

    function automatic rec_t observed();
        rec_t r;
        r.op = out_opcode; r.rd = out_rd; r.rs1 = out_rs1; r.rs2 = out_rs2;
        r.flg = {out_rd_wr, out_rs1_used, out_rs2_used, out_illegal};
        r.pc = out_pc; r.cnt = illegal_count;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare the presented entry against the scoreboard head every cycle it is valid;
    // retire the head when the downstream takes it.
    initial begin
        rec_t a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready", in_ready, !out_valid || out_ready);
                if (out_valid) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_output: out_valid=1 pc=%h op=%s, expected no entry", out_pc, out_opcode.name());
                    end else begin
                        a = observed();
                        if (a !== exp_q[0]) begin
                            fails++;
                            $display("FAIL scoreboard: got op=%s rd=%0d rs1=%0d rs2=%0d flg=%b pc=%h cnt=%0d, expected op=%s rd=%0d rs1=%0d rs2=%0d flg=%b pc=%h cnt=%0d",
                                     a.op.name(), a.rd, a.rs1, a.rs2, a.flg, a.pc, a.cnt,
                                     exp_q[0].op.name(), exp_q[0].rd, exp_q[0].rs1, exp_q[0].rs2,
                                     exp_q[0].flg, exp_q[0].pc, exp_q[0].cnt);
                        end
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction; on the accepting cycle push its expected decode.
    task automatic send(input logic [31:0] ins, input rec_t e);
        bit acc = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc_next;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            waited++;
            if (in_ready) begin
                acc = 1'b1;
                if (e.flg[0] && mcnt != 2'd3) mcnt = mcnt + 2'd1;
                e.pc  = pc_next;
                e.cnt = mcnt;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        pc_next  = pc_next + 32'd4;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL accept_timeout: instr %h not accepted in 50 cycles", ins);
        end
    endtask

    task automatic do_flush(input logic v, input logic [31:0] ins);
        flush    = 1'b1;
        in_valid = v;
        in_instr = ins;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_valid", out_valid, 1'b0);
        check("flush_count", illegal_count, mcnt);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_count", illegal_count, 2'd0);
        check("rst_opcode", out_opcode, OP_NOP);
        check("rst_payload", {out_rd, out_rs1, out_rs2, out_rd_wr, out_rs1_used, out_rs2_used, out_illegal, out_pc}, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Back-to-back R-type, one per cycle.
        send(32'h002081B3, mk(OP_ADD, 5'd3, 5'd1, 5'd2, 4'b1110)); check("b2b_add_cycles", waited, 1);
        send(32'h402081B3, mk(OP_SUB, 5'd3, 5'd1, 5'd2, 4'b1110)); check("b2b_sub_cycles", waited, 1);
        send(32'h022081B3, mk(OP_MUL, 5'd3, 5'd1, 5'd2, 4'b1110)); check("b2b_mul_cycles", waited, 1);
        idle(2);

        // Stall: ECALL held 5 cycles, EBREAK accepted on the edge that releases it.
        out_ready = 1'b0;
        send(32'h00000073, mk(OP_ECALL, 5'd0, 5'd0, 5'd0, 4'b0000));
        fork
            send(32'h00100073, mk(OP_EBREAK, 5'd0, 5'd0, 5'd0, 4'b0000));
            begin repeat (5) @(posedge clk); #1 out_ready = 1'b1; end
        join
        check("stall_accept_cycle", waited, 6);
        idle(2);

        // Use flags and index zeroing.
        send(32'hFFFFF2B7, mk(OP_LUI,   5'd5, 5'd0, 5'd0, 4'b1000));
        send(32'h00000013, mk(OP_ADDI,  5'd0, 5'd0, 5'd0, 4'b0100));
        send(32'h0000A183, mk(OP_LW,    5'd3, 5'd1, 5'd0, 4'b1100));
        send(32'h0020A023, mk(OP_SW,    5'd0, 5'd1, 5'd2, 4'b0110));
        send(32'h00208063, mk(OP_BEQ,   5'd0, 5'd1, 5'd2, 4'b0110));
        send(32'h0FF0000F, mk(OP_NOP,   5'd0, 5'd0, 5'd0, 4'b0000));
        send(32'h4010D093, mk(OP_SRAI,  5'd1, 5'd1, 5'd0, 4'b1100));
        send(32'h008000EF, mk(OP_JAL,   5'd1, 5'd0, 5'd0, 4'b1000));
        idle(2);

        // Flush of an incoming illegal instruction: dropped and not counted.
        do_flush(1'b1, 32'hFFFFFFFF);
        idle(1);

        // Flush of a stalled entry.
        out_ready = 1'b0;
        send(32'h002081B3, mk(OP_ADD, 5'd3, 5'd1, 5'd2, 4'b1110));
        idle(2);
        do_flush(1'b0, 32'h0);
        out_ready = 1'b1;
        idle(2);

        // Illegal encodings and counter saturation at 3.
        send(32'hFFFFFFFF, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 4'b0001));
        send(32'h00200073, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 4'b0001));
        send(32'h0000305F, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 4'b0001));
        send(32'h00000000, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 4'b0001));
        send(32'h0020A063, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 4'b0001));
        send(32'h40109093, mk(OP_NOP, 5'd0, 5'd0, 5'd0, 4'b0001));
        idle(2);
        check("sat_count", illegal_count, 2'd3);
        check("sb_drained", exp_q.size(), 0);

        // Asynchronous reset with an entry held.
        out_ready = 1'b0;
        send(32'h002081B3, mk(OP_ADD, 5'd3, 5'd1, 5'd2, 4'b1110));
        idle(1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_count", illegal_count, 2'd0);
        check("arst_opcode", out_opcode, OP_NOP);
        exp_q.delete();
        mcnt = 2'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
